// File: rtl/sram_controller_pkg.sv
// Shared constants and state encoding for the 16-bit asynchronous SRAM controller.
package sram_controller_pkg;

  localparam int SRAM_DATA_LEN = 16;
  localparam int SRAM_ADDR_LEN = 18;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_LOW  = 2'd1,
    SRAM_HIGH = 2'd2,
    SRAM_DONE = 2'd3
  } sram_state_e;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request bus plus board SRAM pins; master is the pipeline/board side, slave the controller.
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic                     wr_en;
  logic                     rd_en;
  logic [31:0]              address;
  logic [31:0]              write_data;
  logic [31:0]              read_data;
  logic                     ready;
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out;
  logic                     sram_dq_oe;
  logic [SRAM_DATA_LEN-1:0] sram_dq_in;
  logic                     sram_we_n;
  logic                     sram_oe_n;
  logic                     sram_ce_n;
  logic                     sram_ub_n;
  logic                     sram_lb_n;

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

endinterface

// File: rtl/sram_controller_wait_counter.sv
// 3-bit wait-state down-counter: loads on request, counts down to zero and holds there.
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_value,
  output logic       zero
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_value;
    else if (cnt_q != 3'd0)
      cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= 3'd0;
    else
      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two half-word SRAM phases with programmable wait states.
// Optional read bypass of the last word read: define SRAM_READ_BYPASS_EN.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus
);

  sram_state_e              state_q, state_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     is_wr_q, is_wr_d;
  logic [SRAM_ADDR_LEN-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DATA_LEN-1:0] dq_out_q, dq_out_d;
  logic                     dq_oe_q, dq_oe_d;
  logic                     we_n_q, we_n_d;
  logic                     oe_n_q, oe_n_d;
  logic                     ce_n_q, ce_n_d;
  logic                     cnt_load, cnt_zero;
  logic                     phase_hi;
  logic [31:0]              off;
  logic                     req, hit;
  logic                     unused_off;

`ifdef SRAM_READ_BYPASS_EN
  logic [29:0] last_addr_q, last_addr_d;
  logic        last_valid_q, last_valid_d;

  assign hit = bus.rd_en & ~bus.wr_en & last_valid_q & (bus.address[31:2] == last_addr_q);
`else
  assign hit = 1'b0;
`endif

  assign req = (bus.wr_en | bus.rd_en) & ~hit;

  sram_wait_counter u_wait (
    .clk        (clk),
    .rst_n      (rst),
    .load       (cnt_load),
    .load_value (3'(WAIT_CYCLES)),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    rdata_d     = rdata_q;
    cnt_load    = 1'b0;
    phase_hi    = 1'b0;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    ce_n_d      = 1'b1;
`ifdef SRAM_READ_BYPASS_EN
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
`endif

    case (state_q)
      SRAM_IDLE: begin
        if (req) begin
          addr_d   = bus.address;
          wdata_d  = bus.write_data;
          is_wr_d  = bus.wr_en;
          cnt_load = 1'b1;
          state_d  = SRAM_LOW;
`ifdef SRAM_READ_BYPASS_EN
          if (bus.wr_en)
            last_valid_d = 1'b0;
`endif
        end
      end
      SRAM_LOW: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          state_d  = SRAM_HIGH;
          if (!is_wr_q)
            rdata_d[15:0] = bus.sram_dq_in;
        end
      end
      SRAM_HIGH: begin
        if (cnt_zero) begin
          state_d = SRAM_DONE;
          if (!is_wr_q)
            rdata_d[31:16] = bus.sram_dq_in;
        end
      end
      SRAM_DONE: begin
        state_d = SRAM_IDLE;
`ifdef SRAM_READ_BYPASS_EN
        if (!is_wr_q) begin
          last_valid_d = 1'b1;
          last_addr_d  = addr_q[31:2];
        end
`endif
      end
    endcase

    // Pin values are registered, so they are derived from the state being entered.
    off = addr_d - ADDR_BASE;
    if (state_d == SRAM_LOW || state_d == SRAM_HIGH) begin
      phase_hi    = (state_d == SRAM_HIGH);
      sram_addr_d = {off[18:2], phase_hi};
      ce_n_d      = 1'b0;
      if (is_wr_d) begin
        we_n_d   = 1'b0;
        dq_oe_d  = 1'b1;
        dq_out_d = phase_hi ? wdata_d[31:16] : wdata_d[15:0];
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  assign unused_off = ^{off[31:19], off[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SRAM_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      is_wr_q     <= 1'b0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      is_wr_q     <= is_wr_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      ce_n_q      <= ce_n_d;
    end
  end

`ifdef SRAM_READ_BYPASS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
    end
  end
`endif

  assign bus.ready       = (state_q == SRAM_DONE) ||
                           ((state_q == SRAM_IDLE) && (!(bus.wr_en || bus.rd_en) || hit));
  assign bus.read_data   = rdata_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_we_n   = we_n_q;
  assign bus.sram_oe_n   = oe_n_q;
  assign bus.sram_ce_n   = ce_n_q;
  assign bus.sram_ub_n   = 1'b0;
  assign bus.sram_lb_n   = 1'b0;

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage responder that services the pipeline's `mem_r_en`/`mem_w_en` requests against an external 16-bit asynchronous SRAM. Each 32-bit word access is split into two half-word SRAM phases with programmable wait states. `ready` is held low while an access is in flight; the top level uses it to freeze every stage register, including the ID/EX register. The block sits between the MEM stage and the board SRAM pins.

## Interface
Parameters:
- `ADDR_BASE`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 1: extra cycles each half-word phase is held (0..7).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request from MEM stage.
- `rd_en`  in  1  read request from MEM stage.
- `address`  in  32  byte address; bits [1:0] ignored.
- `write_data`  in  32  word to store.
- `read_data`  out  32  registered read result.
- `ready`  out  1  high when no stall is required.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_out`  out  16  data driven to SRAM.
- `sram_dq_oe`  out  1  tri-state enable for `sram_dq_out` (top level builds the inout).
- `sram_dq_in`  in  16  data sampled from SRAM.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`  out  1 each  active-low SRAM strobes.
- `sram_ub_n`, `sram_lb_n`  out  1 each  byte lanes; tied 0 (full half-word access).

## Operation
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If `wr_en|rd_en` and not a bypass hit, latch `address`, `write_data` and op into internal registers, load the wait counter with `WAIT_CYCLES`, then go to LOW.
  - `wr_en&rd_en` together is treated as a write.
- Half-word address: `sram_addr = {(address - ADDR_BASE)[18:2], h}`, where h=0 in LOW and h=1 in HIGH.
- LOW and HIGH:
  - Each lasts `WAIT_CYCLES+1` cycles. The counter decrements, and the state advances when the counter is 0.
  - `sram_ce_n=0` throughout.
  - Write: `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_out` = `write_data[15:0]` (LOW) or `[31:16]` (HIGH).
  - Read: `sram_oe_n=0`. On the final cycle of LOW, `sram_dq_in` is captured into `read_data[15:0]`; on the final cycle of HIGH, into `read_data[31:16]`.
- DONE: strobes inactive, `ready=1`; next state is IDLE unconditionally.
- `ready` (combinational): 1 in DONE; in IDLE, 1 when no request or on a bypass hit; otherwise 0.
- Request inputs are ignored outside IDLE, because the latched copy governs the access.
- Out-of-range addresses (below `ADDR_BASE`) wrap modulo 2^18 half-words and are not flagged.

## Timing
- Reset values: state IDLE, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `sram_oe_n`=1, `sram_ce_n`=1, internal latches 0, bypass valid=0.
- Reset asserted mid-access:
  - Immediate return to IDLE with all strobes inactive.
  - A partial write may leave only the low half written; this is accepted.
- Full access latency is `2*(WAIT_CYCLES+1)+2` cycles from the request-seen IDLE cycle to the DONE cycle inclusive. With `WAIT_CYCLES=1` this is 6 cycles, with `ready` high only in the 6th.
- The pipeline advances on the edge ending DONE. A request still asserted in the following IDLE cycle is a new access.
- `read_data` holds its value until the next read capture.

## Configuration
- `SRAM_READ_BYPASS_EN` defined:
  - The block keeps `last_addr[31:2]` and `last_valid`; DONE of a read sets `last_valid=1`.
  - Any write latched in IDLE clears `last_valid`.
  - In IDLE, `rd_en` with `last_valid` and a matching `address[31:2]` is a hit: `ready=1` in the same cycle, no SRAM activity, state stays IDLE, and `read_data` is reused.
- Not defined: no bypass registers; every read takes the full latency.

## Structure
- Shared `Constants.v` gains:
  - `SRAM_DATA_LEN` (16) and `SRAM_ADDR_LEN` (18).
  - State encodings `SRAM_IDLE`/`SRAM_LOW`/`SRAM_HIGH`/`SRAM_DONE` (2 bits).
- One sub-module, `sram_wait_counter`:
  - 3-bit down-counter with `load`, `load_value`, and `zero` output.
  - Asynchronous active-low reset.

## Test plan
- Reset: assert `rst`=0 during the HIGH phase of a write -> next sample shows state IDLE, `sram_we_n`=1, `sram_dq_oe`=0, `ready`=1 with no request.
- Write 0xDEADBEEF to 1024 (`WAIT_CYCLES`=1) -> LOW: `sram_addr`=0, dq 0xBEEF for 2 cycles; HIGH: `sram_addr`=1, dq 0xDEAD for 2 cycles; `ready`=1 in cycle 6 only.
- Read 1024 after that write, SRAM model returns stored data -> `read_data`=0xDEADBEEF in DONE; `sram_oe_n`=0 for cycles 2–5; `sram_we_n` stays 1.
- Address 1028 with `rd_en` -> `sram_addr` 2 then 3.
- Bypass (`SRAM_READ_BYPASS_EN` defined):
  - Read 1024, then read 1024 again -> second request sees `ready`=1 in its first cycle, no SRAM strobes.
  - Read 1024, write 2000, read 1024 -> second read takes the full 6 cycles.
- `rd_en`=`wr_en`=1, address 1032, data 0x12345678 -> write performed (`sram_we_n`=0, dq 0x5678 then 0x1234); `read_data` unchanged.
